link_align_rx: RTL and testbench

- Receive-side counterpart of the team's output data mux / idle-word link transmitter.
- Accepts the raw word stream from a deserialiser as AXIS and restores the transmitter's bit order (optional reversal).
- Finds word alignment by searching bit offsets for the idle / BX0-idle pattern sent after link reset, then confirms lock.
- Once locked, forwards aligned payload words downstream, flagging BX0 and idle words.

---
 rtl/link_pkg.sv | 27 ++
 rtl/link_align_rx_if.sv | 25 ++
 rtl/link_bit_window.sv | 35 +++
 rtl/link_align_rx.sv | 134 +++++++++++++
 tb/tb_link_align_rx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the idle-word link: receiver FSM states and the bit-order
// helper used by both the transmit mux and the receive aligner.
package link_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  localparam int unsigned LINK_MAX_WIDTH = 256;
  localparam int unsigned LINK_IDX_W     = $clog2(LINK_MAX_WIDTH);

  // Reverses the low 'width' bits of word; bits above 'width' come back as zero.
  function automatic logic [LINK_MAX_WIDTH-1:0] reverse_bits(
    input logic [LINK_MAX_WIDTH-1:0] word,
    input int unsigned               width
  );
    logic [LINK_MAX_WIDTH-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < LINK_MAX_WIDTH; i++) begin
      if (i < width) rev[LINK_IDX_W'(i)] = word[LINK_IDX_W'(width - 1 - i)];
    end
    return rev;
  endfunction

endpackage

// File: rtl/link_align_rx_if.sv
// Raw-in / aligned-out stream bundle of the link receiver; slave is the receiver side.
interface link_align_rx_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata_in;
  logic                  tvalid_in;
  logic                  tready_in;
  logic [DATA_WIDTH-1:0] tdata_out;
  logic                  tvalid_out;
  logic                  tuser_bx0_out;
  logic                  tuser_idle_out;
  logic                  tready_out;

  modport slave (
    input  tdata_in, tvalid_in, tready_out,
    output tready_in, tdata_out, tvalid_out, tuser_bx0_out, tuser_idle_out
  );

  modport master (
    output tdata_in, tvalid_in, tready_out,
    input  tready_in, tdata_out, tvalid_out, tuser_bx0_out, tuser_idle_out
  );

endinterface

// File: rtl/link_bit_window.sv
// Restores transmit bit order and extracts the DATA_WIDTH-bit window at the current
// bit offset from the current and previous accepted words.
module link_bit_window
  import link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned INPUT_REVERSE_BITS = 1
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          accept_i,
  input  logic [DATA_WIDTH-1:0]         tdata_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] bit_offset_i,
  output logic [DATA_WIDTH-1:0]         window_o
);

  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] prev_q;

  always_comb begin
    if (INPUT_REVERSE_BITS != 0)
      word_r = DATA_WIDTH'(reverse_bits(LINK_MAX_WIDTH'(tdata_i), DATA_WIDTH));
    else
      word_r = tdata_i;
    window_o = DATA_WIDTH'({word_r, prev_q} >> bit_offset_i);
  end

  always_ff @(posedge clk) begin
    if (!aresetn)
      prev_q <= '0;
    else if (accept_i)
      prev_q <= word_r;
  end

endmodule

// File: rtl/link_align_rx.sv
// Link receiver: searches bit offsets for the idle pattern, confirms lock over
// n_lock_words consecutive matches, then forwards aligned words with BX0/idle flags.
module link_align_rx
  import link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned INPUT_REVERSE_BITS = 1,
  parameter int unsigned DROP_IDLE          = 1
) (
  input  logic                          clk,
  input  logic                          aresetn,
  link_align_rx_if.slave                axis,
  input  logic [DATA_WIDTH-1:0]         idle_word,
  input  logic [DATA_WIDTH-1:0]         idle_word_BX0,
  input  logic [15:0]                   n_lock_words,
  input  logic                          resync,
  output logic                          locked,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_offset
);

  localparam int unsigned    OW       = $clog2(DATA_WIDTH);
  localparam logic [OW-1:0]  OFF_LAST = OW'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic [OW-1:0]         off_q, off_d, off_next;
  logic [15:0]           cnt_q, cnt_d, cnt_inc, thr;
  logic                  resync_q, resync_edge;
  logic                  accept, match, is_bx0, is_idle;
  logic [DATA_WIDTH-1:0] window;

  logic                  tvalid_q, bx0_q, idle_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  assign accept         = axis.tvalid_in && axis.tready_out;
  assign axis.tready_in = axis.tready_out;

  link_bit_window #(
    .DATA_WIDTH         (DATA_WIDTH),
    .INPUT_REVERSE_BITS (INPUT_REVERSE_BITS)
  ) u_window (
    .clk          (clk),
    .aresetn      (aresetn),
    .accept_i     (accept),
    .tdata_i      (axis.tdata_in),
    .bit_offset_i (off_q),
    .window_o     (window)
  );

  assign is_bx0      = (window == idle_word_BX0);
  assign is_idle     = (window == idle_word);
  assign match       = is_idle || is_bx0;
  assign resync_edge = resync && !resync_q;
  assign thr         = (n_lock_words == '0) ? 16'd1 : n_lock_words;
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
  assign off_next    = (off_q == OFF_LAST) ? '0 : off_q + OW'(1);

  // The beat whose match reaches the threshold moves straight to LOCKED, so locked
  // rises one clock after it; the CONFIRM threshold check also covers a threshold
  // lowered while confirming.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    if (resync_edge) begin
      state_d = SEARCH;
      off_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (accept) begin
            if (match) begin
              cnt_d   = 16'd1;
              state_d = (thr <= 16'd1) ? LOCKED : CONFIRM;
            end else begin
              off_d = off_next;
            end
          end
        end
        CONFIRM: begin
          if (cnt_q >= thr) begin
            state_d = LOCKED;
          end else if (accept) begin
            if (match) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= thr) state_d = LOCKED;
            end else begin
              state_d = SEARCH;
              off_d   = off_next;
            end
          end
        end
        LOCKED:  state_d = LOCKED;
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= SEARCH;
      off_q    <= '0;
      cnt_q    <= '0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      resync_q <= resync;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      bx0_q    <= 1'b0;
      idle_q   <= 1'b0;
    end else if (axis.tready_out) begin
      tvalid_q <= accept && (state_q == LOCKED) && !((DROP_IDLE != 0) && match);
      tdata_q  <= window;
      bx0_q    <= is_bx0;
      idle_q   <= match;
    end
  end

  assign axis.tvalid_out     = tvalid_q;
  assign axis.tdata_out      = tdata_q;
  assign axis.tuser_bx0_out  = bx0_q;
  assign axis.tuser_idle_out = idle_q;
  assign locked              = (state_q == LOCKED);
  assign bit_offset          = off_q;

endmodule

// File: tb/tb_link_align_rx.sv
// Directed bench for link_align_rx: two instances (idle kept / idle dropped) fed the
// same serial idle/payload stream at a chosen bit shift; outputs checked via a scoreboard.
module tb_link_align_rx;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] IDLE = 32'h9CCC_CCCC;
  localparam logic [W-1:0] BX0W = 32'h9CCC_CCCD;
  localparam logic [W-1:0] PAY  = 32'h1234_5678;
  localparam logic [W-1:0] PAY2 = 32'hA5A5_0F0F;
  localparam logic [W-1:0] PAY3 = 32'h3C3C_3C3C;
  localparam logic [W-1:0] BAD  = 32'hDEAD_BEEF;

  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] d;
    logic         bx0;
    logic         idle;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn, resync;
  logic [W-1:0] idle_word, idle_word_BX0;
  logic [15:0]  n_lock_words;
  logic         locked_k, locked_d;
  logic [4:0]   off_k, off_d;

  link_align_rx_if #(.DATA_WIDTH(W)) bus_k ();
  link_align_rx_if #(.DATA_WIDTH(W)) bus_d ();

  link_align_rx #(.DATA_WIDTH(W), .INPUT_REVERSE_BITS(1), .DROP_IDLE(0)) u_keep (
    .clk(clk), .aresetn(aresetn), .axis(bus_k),
    .idle_word(idle_word), .idle_word_BX0(idle_word_BX0), .n_lock_words(n_lock_words),
    .resync(resync), .locked(locked_k), .bit_offset(off_k)
  );

  link_align_rx #(.DATA_WIDTH(W), .INPUT_REVERSE_BITS(1), .DROP_IDLE(1)) u_drop (
    .clk(clk), .aresetn(aresetn), .axis(bus_d),
    .idle_word(idle_word), .idle_word_BX0(idle_word_BX0), .n_lock_words(n_lock_words),
    .resync(resync), .locked(locked_d), .bit_offset(off_d)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  exp_t        last_e;
  logic [W-1:0] tx_last = '0;
  int unsigned  shift_s = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [W-1:0] rev32(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int unsigned i = 0; i < W; i++) y[5'(i)] = x[5'(W - 1 - i)];
    return y;
  endfunction

  // Deserialiser word seen when tx word t follows tx_last, with the stream slipped by shift_s bits.
  function automatic logic [W-1:0] raw_of(input logic [W-1:0] t);
    logic [2*W-1:0] pair;
    pair = {t, tx_last} >> (W - shift_s);
    return pair[W-1:0];
  endfunction

  task automatic drive(input logic [W-1:0] raw, input logic v, input logic rdy);
    bus_k.tdata_in  = rev32(raw);
    bus_d.tdata_in  = rev32(raw);
    bus_k.tvalid_in = v;
    bus_d.tvalid_in = v;
    bus_k.tready_out = rdy;
    bus_d.tready_out = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] t, input logic fwd);
    exp_t e;
    drive(raw_of(t), 1'b1, 1'b1);
    e.d    = tx_last;
    e.bx0  = (tx_last == BX0W);
    e.idle = (tx_last == IDLE) || (tx_last == BX0W);
    e.v0   = fwd;
    e.v1   = fwd && !e.idle;
    sb.push_back(e);
    tx_last = t;
    tick();
    drive('0, 1'b0, 1'b1);
    e = sb.pop_front();
    chk("tvalid_keep", 64'(bus_k.tvalid_out), 64'(e.v0));
    chk("tvalid_drop", 64'(bus_d.tvalid_out), 64'(e.v1));
    if (e.v0) begin
      chk("tdata_keep", 64'(bus_k.tdata_out), 64'(e.d));
      chk("bx0_keep", 64'(bus_k.tuser_bx0_out), 64'(e.bx0));
      chk("idle_keep", 64'(bus_k.tuser_idle_out), 64'(e.idle));
    end
    if (e.v1) chk("tdata_drop", 64'(bus_d.tdata_out), 64'(e.d));
    last_e = e;
  endtask

  task automatic do_resync();
    drive('0, 1'b0, 1'b1);
    resync = 1'b1;
    tick();
    chk("resync_locked", 64'(locked_k), 64'd0);
    chk("resync_off", 64'(off_k), 64'd0);
    chk("resync_tvalid", 64'(bus_k.tvalid_out), 64'd0);
    resync = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; resync = 1'b0;
    idle_word = IDLE; idle_word_BX0 = BX0W; n_lock_words = 16'd4;
    drive('0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("rst_locked", 64'(locked_k), 64'd0);
    chk("rst_off", 64'(off_k), 64'd0);
    chk("rst_tvalid", 64'(bus_k.tvalid_out), 64'd0);
    chk("rst_tdata", 64'(bus_k.tdata_out), 64'd0);
    chk("rst_bx0", 64'(bus_k.tuser_bx0_out), 64'd0);
    chk("rst_idle", 64'(bus_k.tuser_idle_out), 64'd0);
    aresetn = 1'b1;

    // Aligned idle stream: first window is the zero reset word, so a full sweep wraps to 0.
    for (int i = 0; i < 36; i++) begin
      send(IDLE, 1'b0);
      if (i == 30) chk("off_before_wrap", 64'(off_k), 64'd31);
      if (i == 31) chk("off_wrap", 64'(off_k), 64'd0);
      if (i == 34) chk("lock_not_early", 64'(locked_k), 64'd0);
    end
    chk("lock0_keep", 64'(locked_k), 64'd1);
    chk("lock0_drop", 64'(locked_d), 64'd1);
    chk("lock0_off", 64'(off_k), 64'd0);
    send(PAY, 1'b1);
    send(BX0W, 1'b1);
    send(IDLE, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(raw_of(PAY2), 1'b1, 1'b0);
      tick();
      chk("bp_tready_in", 64'(bus_k.tready_in), 64'd0);
      chk("bp_hold_valid", 64'(bus_k.tvalid_out), 64'(last_e.v0));
      chk("bp_hold_data", 64'(bus_k.tdata_out), 64'(last_e.d));
      chk("bp_hold_off", 64'(off_k), 64'd0);
    end
    send(PAY2, 1'b1);
    send(PAY3, 1'b1);

    do_resync();
    shift_s = 5;
    for (int i = 0; i < 9; i++) begin
      send(IDLE, 1'b0);
      if (i == 4) chk("off5_reached", 64'(off_k), 64'd5);
      if (i == 7) chk("lock5_not_early", 64'(locked_k), 64'd0);
    end
    chk("lock5", 64'(locked_k), 64'd1);
    chk("lock5_off", 64'(off_k), 64'd5);
    send(PAY, 1'b1);
    send(BX0W, 1'b1);
    send(IDLE, 1'b1);
    send(IDLE, 1'b1);

    // Two confirming matches, then a bad word breaks confirmation.
    do_resync();
    for (int i = 0; i < 8; i++) begin
      send((i == 6) ? BAD : IDLE, 1'b0);
      if (i == 6) chk("confirm_off", 64'(off_k), 64'd5);
    end
    chk("confirm_fail_locked", 64'(locked_k), 64'd0);
    chk("confirm_fail_off", 64'(off_k), 64'd6);

    do_resync();
    for (int i = 0; i < 7; i++) send(IDLE, 1'b0);
    chk("midconf_locked", 64'(locked_k), 64'd0);
    chk("midconf_off", 64'(off_k), 64'd5);
    aresetn = 1'b0;
    drive('0, 1'b0, 1'b1);
    tick();
    chk("rst2_locked", 64'(locked_k), 64'd0);
    chk("rst2_off", 64'(off_k), 64'd0);
    chk("rst2_tvalid", 64'(bus_k.tvalid_out), 64'd0);
    chk("rst2_tdata", 64'(bus_k.tdata_out), 64'd0);
    chk("rst2_idle", 64'(bus_k.tuser_idle_out), 64'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(IDLE, 1'b0);
      if (i == 7) chk("relock_not_early", 64'(locked_k), 64'd0);
    end
    chk("relock", 64'(locked_k), 64'd1);
    chk("relock_off", 64'(off_k), 64'd5);
    send(PAY, 1'b1);
    send(IDLE, 1'b1);

    // A zero threshold behaves as one: the first match locks.
    do_resync();
    n_lock_words = 16'd0;
    for (int i = 0; i < 6; i++) begin
      send(IDLE, 1'b0);
      if (i == 4) chk("n0_not_early", 64'(locked_k), 64'd0);
    end
    chk("n0_locked", 64'(locked_k), 64'd1);
    chk("n0_off", 64'(off_k), 64'd5);
    send(IDLE, 1'b1);
    send(PAY, 1'b1);
    send(IDLE, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
